// File: rtl/ai_i2s_pkg.sv
// ai_i2s_pkg: shared types and default constants for the I2S slave receiver.
//   i2s_state_e      : receiver FSM state (IDLE, LEFT, RIGHT)
//   I2S_SAMPLE_WIDTH : default bits kept per channel
//   I2S_FIFO_DEPTH   : default number of stereo pairs buffered
package ai_i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int I2S_SAMPLE_WIDTH = 16;
  localparam int I2S_FIFO_DEPTH   = 4;

endpackage

// File: rtl/ai_i2s_sync_fifo.sv
// ai_i2s_sync_fifo: single-clock FIFO whose head entry is a register, so
// rdata_o comes straight from a flop and never changes without a pop.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : write push_data_i (dropped with overrun_o if full and no pop)
//   pop_i         : consumer accept; ignored while empty
//   rdata_o       : head entry; valid_o : FIFO not empty
//   level_o       : number of stored entries
//   overrun_o     : one-cycle pulse, registered, when a push was dropped
module ai_i2s_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overrun_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [LVL_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, do_pop, do_push;
  logic [LVL_W-1:0] wr_pos;

  // Entry 0 is always the head: a pop shifts everything down one slot and a
  // push lands in the first free slot (one lower when popping at the same time).
  always_comb begin
    mem_d     = mem_q;
    count_d   = count_q;
    full      = (count_q == LVL_W'(DEPTH));
    do_pop    = pop_i && (count_q != '0);
    do_push   = push_i && (!full || do_pop);
    overrun_d = push_i && full && !do_pop;
    wr_pos    = do_pop ? (count_q - LVL_W'(1)) : count_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
    end
    if (do_push) begin
      mem_d[wr_pos[LVL_W-2:0]] = push_data_i;
    end
    count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rdata_o   = mem_q[0];
  assign valid_o   = (count_q != '0);
  assign level_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/ai_i2s_slave_rx.sv
// ai_i2s_slave_rx: I2S slave receiver. Synchronizes the external SCK/WS/SD
// lines into wb_clk_i, deserializes left/right words MSB first with the I2S
// one-bit WS delay, and buffers {left,right} pairs in a small FIFO.
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   enable_i                  : receiver enable (low = hold FSM in IDLE)
//   i2s_sck_in/ws_in/sd_in    : asynchronous I2S bit clock, word select, data
//   rx_data_valid/rx_data     : FIFO head {left, right}
//   rx_data_ready             : consumer accept
//   fifo_level_o              : stored pair count
//   overrun_o                 : pulse, a pair was dropped (FIFO full)
//   frame_err_o               : pulse, a closed word was shorter than SAMPLE_WIDTH
//   state_o                   : current FSM state (debug)
// Handshake: a pair transfers on every cycle where rx_data_valid and
// rx_data_ready are both high; while valid is high and ready is low,
// rx_data holds its value; valid never depends on ready.
module ai_i2s_slave_rx
  import ai_i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int DATA_WIDTH   = 2 * SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = I2S_FIFO_DEPTH
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic                          i2s_sck_in,
  input  logic                          i2s_ws_in,
  input  logic                          i2s_sd_in,
  output logic                          rx_data_valid,
  output logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  output i2s_state_e                    state_o
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam int IDX_W = $clog2(SAMPLE_WIDTH);

  // Synchronizer bit order: {sck, ws, sd}
  logic [2:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic                    sck_prev_q, sck_prev_d;
  i2s_state_e              state_q, state_d;
  logic                    ws_prev_q, ws_prev_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0]   pair_q, pair_d;
  logic                    push_q, push_d;
  logic                    frame_err_q, frame_err_d;

  logic                    strobe, ws_s, sd_s, ws_rise, ws_fall, short_word;
  logic [SAMPLE_WIDTH-1:0] word_bits;
  logic [CNT_W-1:0]        bits_new;
  logic [IDX_W-1:0]        wr_idx;

  always_comb begin
    sync1_d    = {i2s_sck_in, i2s_ws_in, i2s_sd_in};
    sync2_d    = sync1_q;
    sck_prev_d = sync2_q[2];
  end

  // All three lines share the same synchronizer latency, so WS/SD seen at
  // the strobe belong to the same SCK rising edge.
  assign strobe  = sync2_q[2] && !sck_prev_q;
  assign ws_s    = sync2_q[1];
  assign sd_s    = sync2_q[0];
  assign ws_rise = strobe && ws_s && !ws_prev_q;
  assign ws_fall = strobe && !ws_s && ws_prev_q;

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    pair_d      = pair_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    // Current word with this strobe's bit appended; bits past SAMPLE_WIDTH
    // are dropped and the counter saturates.
    word_bits = shift_q;
    bits_new  = cnt_q;
    wr_idx    = IDX_W'(SAMPLE_WIDTH - 1) - cnt_q[IDX_W-1:0];
    if (cnt_q < CNT_W'(SAMPLE_WIDTH)) begin
      word_bits[wr_idx] = sd_s;
      bits_new          = cnt_q + CNT_W'(1);
    end
    short_word = (bits_new < CNT_W'(SAMPLE_WIDTH));

    // WS history keeps tracking while disabled so re-enable resyncs cleanly.
    if (strobe) begin
      ws_prev_d = ws_s;
    end

    if (!enable_i) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          // Bit at the WS fall closes a word we never saw start: discard it.
          if (ws_fall) begin
            state_d = LEFT;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
        LEFT: begin
          if (ws_rise) begin
            left_d      = word_bits;
            frame_err_d = short_word;
            state_d     = RIGHT;
            shift_d     = '0;
            cnt_d       = '0;
          end else begin
            shift_d = word_bits;
            cnt_d   = bits_new;
          end
        end
        RIGHT: begin
          if (ws_fall) begin
            pair_d      = {left_q, word_bits};
            push_d      = 1'b1;
            frame_err_d = short_word;
            state_d     = LEFT;
            shift_d     = '0;
            cnt_d       = '0;
          end else begin
            shift_d = word_bits;
            cnt_d   = bits_new;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= IDLE;
      ws_prev_q   <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      left_q      <= '0;
      pair_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      ws_prev_q   <= ws_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      pair_q      <= pair_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  ai_i2s_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_i      (push_q),
    .push_data_i (pair_q),
    .pop_i       (rx_data_ready),
    .rdata_o     (rx_data),
    .valid_o     (rx_data_valid),
    .level_o     (fifo_level_o),
    .overrun_o   (overrun_o)
  );

  assign frame_err_o = frame_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ai_i2s_slave_rx.sv
// tb_ai_i2s_slave_rx: drives I2S serial streams into ai_i2s_slave_rx and
// compares received pairs and pulse counts against a word-level model.
module tb_ai_i2s_slave_rx;

  localparam int SW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;
  logic ready = 1'b0;

  logic          rx_data_valid;
  logic [DW-1:0] rx_data;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic          frame_err;
  ai_i2s_pkg::i2s_state_e dbg_state;

  always #5 clk = ~clk;

  ai_i2s_slave_rx #(
    .SAMPLE_WIDTH (SW),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .enable_i      (enable),
    .i2s_sck_in    (sck),
    .i2s_ws_in     (ws),
    .i2s_sd_in     (sd),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_data_ready (ready),
    .fifo_level_o  (fifo_level),
    .overrun_o     (overrun),
    .frame_err_o   (frame_err),
    .state_o       (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic          bit_q[$];
  logic          ch_q[$];
  int            sck_half = 40;
  int            ready_mode = 2;   // 0: hold low, 1: random, 2: hold high
  int            fe_cnt = 0, fe_long = 0, ov_cnt = 0, ov_long = 0, unstable = 0;
  logic          fe_prev = 1'b0, ov_prev = 1'b0, prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // ---------------- reference model ----------------
  // A channel word of n bits, MSB first, as kept in SW bits.
  function automatic logic [SW-1:0] fit(input logic [31:0] w, input int n);
    logic [31:0] v;
    if (n >= SW) v = w >> (n - SW);
    else         v = w << (SW - n);
    return v[SW-1:0];
  endfunction

  task automatic add_word(input logic ch, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_q.push_back(w[i]);
      ch_q.push_back(ch);
    end
  endtask

  task automatic add_pair(input logic [31:0] l, input int nl,
                          input logic [31:0] r, input int nr, input bit keep);
    add_word(1'b0, l, nl);
    add_word(1'b1, r, nr);
    if (keep) exp_q.push_back({fit(l, nl), fit(r, nr)});
  endtask

  // ---------------- drivers ----------------
  // WS leads the data by one bit: the bit at position j is sent with the WS
  // of the word that bit j+1 belongs to.
  task automatic play(input int max_bits);
    int n;
    n = bit_q.size();
    if (max_bits < n) n = max_bits;
    for (int j = 0; j < n; j++) begin
      ws  = (j + 1 < bit_q.size()) ? ch_q[j+1] : ch_q[j];
      sd  = bit_q[j];
      sck = 1'b0;
      #(sck_half);
      sck = 1'b1;
      #(sck_half);
    end
    bit_q.delete();
    ch_q.delete();
  endtask

  task automatic resync();
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid && ready) begin
        if (exp_q.size() == 0) check("pop_pending", 64'(exp_q.size() != 0), 64'd1);
        else                   check("rx_data", rx_data, exp_q.pop_front());
      end
      if (prev_hold && rx_data !== prev_data) unstable++;
      prev_hold = rx_data_valid && !ready;
      prev_data = rx_data;
      if (frame_err) begin
        fe_cnt++;
        if (fe_prev) fe_long++;
      end
      if (overrun) begin
        ov_cnt++;
        if (ov_prev) ov_long++;
      end
      fe_prev = frame_err;
      ov_prev = overrun;
    end else begin
      prev_hold = 1'b0;
      fe_prev   = 1'b0;
      ov_prev   = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int fe0, ov0, fe_exp, nl, nr;
    logic [31:0] l, r;

    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_data_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk); #1 rst = 1'b0; enable = 1'b1;

    // Two stereo frames, 16-bit, SCK = clk/8
    fe0 = fe_cnt; ov0 = ov_cnt; ready_mode = 2; sck_half = 40;
    add_word(1'b1, 32'h5, 4);
    add_pair(32'hA5C3, 16, 32'h1234, 16, 1);
    add_pair(32'hFFFF, 16, 32'h0001, 16, 1);
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t1_drain");
    check("t1_frame_err", fe_cnt - fe0, 0);
    check("t1_overrun", ov_cnt - ov0, 0);

    // Start mid-right-channel: partial word must be discarded
    resync();
    fe0 = fe_cnt; ready_mode = 1;
    add_word(1'b1, $urandom, 7);
    add_pair($urandom, 16, $urandom, 16, 1);
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t2_drain");
    check("t2_frame_err", fe_cnt - fe0, 0);

    // 24-bit words: truncated, no error
    resync();
    fe0 = fe_cnt;
    add_word(1'b1, $urandom, 5);
    add_pair(32'hABCDEF, 24, 32'h123456, 24, 1);
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t3_drain");
    check("t3_frame_err", fe_cnt - fe0, 0);

    // 12-bit words: zero-padded, two single-cycle error pulses
    resync();
    fe0 = fe_cnt;
    add_word(1'b1, $urandom, 5);
    add_pair(32'hABC, 12, 32'h123, 12, 1);
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t4_drain");
    check("t4_frame_err", fe_cnt - fe0, 2);
    check("t4_frame_err_width", fe_long, 0);

    // Overrun: six frames with the consumer stalled
    ready_mode = 0;
    resync();
    ov0 = ov_cnt;
    add_word(1'b1, $urandom, 5);
    for (int i = 0; i < 6; i++) add_pair($urandom, 16, $urandom, 16, i < DEPTH);
    add_word(1'b0, $urandom, 3);
    play(1000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_level", fifo_level, DEPTH);
    check("t5_valid", rx_data_valid, 1);
    check("t5_head", rx_data, exp_q[0]);
    check("t5_overrun", ov_cnt - ov0, 2);
    check("t5_overrun_width", ov_long, 0);
    ready_mode = 2;
    wait_drain("t5_drain");
    check("t5_level_empty", fifo_level, 0);

    // Reset after 8 bits of a left word
    resync();
    add_word(1'b1, $urandom, 5);
    add_pair($urandom, 16, $urandom, 16, 0);
    play(13);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_valid", rx_data_valid, 0);
    check("t6_data", rx_data, 0);
    check("t6_level", fifo_level, 0);
    check("t6_overrun", overrun, 0);
    check("t6_frame_err", frame_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    add_word(1'b1, $urandom, 4);
    add_pair($urandom, 16, $urandom, 16, 1);
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t6_drain");

    // Random word lengths, values, SCK rate and consumer stalls
    resync();
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
    ready_mode = 1;
    sck_half = $urandom_range(25, 50);
    add_word(1'b1, $urandom, $urandom_range(2, 10));
    for (int i = 0; i < 8; i++) begin
      nl = $urandom_range(8, 24);
      nr = $urandom_range(8, 24);
      l  = $urandom;
      r  = $urandom;
      add_pair(l, nl, r, nr, 1);
      fe_exp += int'(nl < SW) + int'(nr < SW);
    end
    add_word(1'b0, $urandom, 3);
    play(1000);
    wait_drain("t7_drain");
    check("t7_frame_err", fe_cnt - fe0, fe_exp);
    check("t7_overrun", ov_cnt - ov0, 0);

    check("rx_data_stable", unstable, 0);
    check("frame_err_width", fe_long, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ai_i2s_slave_rx.md
AI_I2S_SLAVE_RX -- requirements
Module: ai_i2s_slave_rx

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 16: bits kept per channel.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: output word width, equal to 2*SAMPLE_WIDTH.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: stereo pairs buffered, a power of 2.
REQ-004 Port wb_clk_i  in  1  is the single system clock; all logic is on its rising edge.
REQ-005 Port wb_rst_i  in  1  is the reset: synchronous, active-high.
REQ-006 Port enable_i  in  1  is the receiver enable.
REQ-007 Port i2s_sck_in  in  1  is the external bit clock; it is asynchronous.
REQ-008 Port i2s_ws_in  in  1  is the external word select (0=left, 1=right); it is asynchronous.
REQ-009 Port i2s_sd_in  in  1  is the serial data, MSB first; it is asynchronous.
REQ-010 Port rx_data_valid  out  1  indicates the FIFO head is valid.
REQ-011 Port rx_data  out  DATA_WIDTH  carries the FIFO head as {left[SAMPLE_WIDTH-1:0], right[SAMPLE_WIDTH-1:0]}.
REQ-012 Port rx_data_ready  in  1  is the consumer accept.
REQ-013 Port fifo_level_o  out  $clog2(FIFO_DEPTH)+1  is the count of stored pairs.
REQ-014 Port overrun_o  out  1  is a one-cycle pulse: a pair was dropped because the FIFO was full.
REQ-015 Port frame_err_o  out  1  is a one-cycle pulse: a channel word was shorter than SAMPLE_WIDTH.

Function
REQ-016 i2s_sck_in, i2s_ws_in and i2s_sd_in SHALL each pass through a 2-flop synchronizer.
- An SCK rising-edge strobe SHALL be derived from the synchronized SCK (current=1, previous=0).
- WS and SD SHALL be sampled only on that strobe.
REQ-017 Correct operation SHALL be required only for a wb_clk_i frequency of at least 4x the SCK frequency.
REQ-018 The block SHALL implement FSM states IDLE, LEFT and RIGHT.
- A WS transition is detected at a strobe where the sampled WS differs from the WS sampled at the previous strobe.
REQ-019 IDLE -> LEFT SHALL occur on the first detected WS 1->0 transition; all bits before it are discarded.
REQ-020 LEFT -> RIGHT SHALL occur on a WS 0->1 transition, and RIGHT -> LEFT on a WS 1->0 transition.
REQ-021 At the strobe where a transition is detected, the SD bit SHALL be the final (LSB) bit of the closing channel word (I2S one-bit delay).
- The next strobe SHALL carry the MSB of the new channel.
REQ-022 Words with more than SAMPLE_WIDTH bits SHALL keep the first SAMPLE_WIDTH bits received and drop the rest, with no error.
REQ-023 Words with fewer than SAMPLE_WIDTH bits SHALL be left-justified and zero-padded, and SHALL pulse frame_err_o for one cycle, in the cycle after the closing strobe.
REQ-024 The bit counter SHALL saturate at SAMPLE_WIDTH and SHALL never wrap.
REQ-025 Closing a RIGHT word SHALL push the {left,right} pair into the FIFO in the cycle after the closing strobe.
REQ-026 rx_data_valid SHALL assert in the cycle after the push into an empty FIFO.
REQ-027 A pop SHALL occur when rx_data_valid && rx_data_ready.
- rx_data SHALL be stable while valid is high and ready is low.
REQ-028 A push into a full FIFO with no pop in the same cycle SHALL drop the new pair and pulse overrun_o; the FIFO contents are unchanged.
REQ-029 A push and a pop in the same cycle with the FIFO full SHALL both succeed: no overrun, level unchanged.
REQ-030 A push and a pop in the same cycle with the FIFO empty SHALL push only, because the pop is gated by valid.
REQ-031 enable_i low SHALL force the FSM to IDLE and clear the shift register and bit counter within one cycle.
- FIFO contents and popping SHALL be unaffected.
- Re-enabling SHALL resync on the next WS 1->0 transition.

Reset
REQ-032 While wb_rst_i is high at a clock edge, the block SHALL reset to the following state:
- FSM=IDLE.
- Synchronizers, shift register and counter cleared.
- FIFO emptied.
- rx_data_valid=0, rx_data=0, fifo_level_o=0, overrun_o=0, frame_err_o=0.
REQ-033 A reset during reception SHALL discard the partial pair; reception SHALL resume only after a fresh WS 1->0 transition.

Structure
REQ-034 Package ai_i2s_pkg SHALL hold the FSM state enum (IDLE, LEFT, RIGHT) and default constants I2S_SAMPLE_WIDTH=16 and I2S_FIFO_DEPTH=4.
REQ-035 The FIFO SHALL be a separate sub-module, ai_i2s_sync_fifo: synchronous, registered head, with level output.
- The FSM, synchronizers and shifter SHALL remain in ai_i2s_slave_rx.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Two stereo frames, SCK = clk/8, 16-bit words left=0xA5C3, right=0x1234, then 0xFFFF/0x0001 -> rx_data=0xA5C31234 then 0xFFFF0001, no error pulses.
- Stream starting mid-right-channel -> partial word discarded; first output pair is the first complete left/right pair.
- 24-bit words 0xABCDEF/0x123456 -> rx_data=0xABCD1234, frame_err_o stays 0.
- 12-bit words 0xABC/0x123 -> rx_data=0xABC01230; frame_err_o pulses twice, 1 cycle each.
- rx_data_ready=0 for 6 frames, FIFO_DEPTH=4 -> fifo_level_o=4; overrun_o pulses exactly twice; the first 4 pairs pop in order.
- Reset asserted after 8 bits of a left word -> all outputs 0; the next complete pair after a WS 1->0 transition is received correctly.
